seg_time_decoder: RTL and testbench
===================================

Name: seg_time_decoder

Overview:
- Receive end of the stopwatch display bus: takes the six 7-segment digit patterns (MM:SS:CC) and recovers binary minutes, seconds and centiseconds.
- Filters glitches, rejects malformed frames and optionally checks that successive readings advance by exactly one centisecond.
- Sits beside the stopwatch as an on-chip monitor and self-check for the display path.

Parameters:
- STABLE_CYCLES, 2, consecutive cycles the six-digit bus must hold one value before it is accepted (range 1..15).
- ACTIVE_LOW, 1, segment polarity: 1 = lit segment is 0 (g..a order, bit6 = g); 0 = inverted.
- CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- digit5  in  7  tens of minutes pattern
- digit4  in  7  units of minutes pattern
- digit3  in  7  tens of seconds pattern
- digit2  in  7  units of seconds pattern
- digit1  in  7  tens of centiseconds pattern
- digit0  in  7  units of centiseconds pattern
- minutes  out  6  last accepted minutes, 0..59
- seconds  out  6  last accepted seconds, 0..59
- centis  out  7  last accepted centiseconds, 0..99
- time_valid  out  1  one-cycle pulse when minutes/seconds/centis update
- fmt_err  out  1  one-cycle pulse when a stable frame is malformed
- step_err  out  1  one-cycle pulse when an accepted frame is not previous + 1 cs
- fmt_err_cnt  out  CNT_W  saturating count of fmt_err pulses
- step_err_cnt  out  CNT_W  saturating count of step_err pulses

Behaviour:
- Reset (rst = 1 at a clk edge): all outputs 0; input register, stability counter, last-frame register and have_prev flag cleared. Reset mid-operation discards any partially filtered frame.
- Input stage: 42-bit concatenation {digit5..digit0} is registered every cycle (in_q). stab_cnt increments, saturating at STABLE_CYCLES, while in_q equals its previous value, and returns to 1 on any change.
- Acceptance event: stab_cnt reaches STABLE_CYCLES, and in_q differs from the last evaluated frame. Each distinct frame is evaluated once; a held frame does not re-fire.
- Latency: input change before edge k is reported at edge k + STABLE_CYCLES, with outputs and pulses visible after that edge.
- Decode: each pattern is mapped through the 0..9 table; with ACTIVE_LOW = 1, 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000. Any other pattern, including hex A..F glyphs and blank, is invalid.
- Format check: any invalid digit, or digit5 > 5, or digit3 > 5, makes the frame malformed.
  - fmt_err pulses.
  - fmt_err_cnt increments unless it is all-ones.
  - minutes, seconds and centis hold.
  - The stored previous time is unchanged.
- Good frame:
  - minutes = 10·d5 + d4, seconds = 10·d3 + d2, centis = 10·d1 + d0, built from unsigned adds with no truncation beyond the port widths.
  - time_valid pulses and have_prev is set.
- Step check (feature enabled):
  - On a good frame with have_prev = 1, the frame is compared to previous + 1 cs.
  - Carries: 99 cs to 0 with seconds + 1; 59 s to 0 with minutes + 1; 59:59:99 wraps to 00:00:00.
  - Mismatch: step_err pulses in the same cycle as time_valid and step_err_cnt saturating-increments.
  - The first good frame after reset is never checked.
  - A malformed frame in between does not clear have_prev; the next good frame is compared to the last good one.
- Simultaneous events: fmt_err and time_valid are mutually exclusive. step_err is only possible together with time_valid.
- Counters: saturate at 2^CNT_W − 1 and never wrap.

Optional Feature:
- Macro: SEG_DECODE_STEP_CHECK_EN.
- Defined: previous-time register, increment/compare logic, step_err and step_err_cnt are implemented as described above.
- Undefined: no previous-time storage; step_err is tied 0 and step_err_cnt is tied 0. All other behaviour is identical.

Test Plan:
- Reset check: rst = 1 for 2 cycles with digits = 00:00:00 patterns, then release → all outputs 0. After STABLE_CYCLES + 1 edges, time_valid pulses once with minutes = 0, seconds = 0, centis = 0.
- Step sequence: drive 12:34:56, hold 5 cycles, then 12:34:57 → time_valid pulses twice, centis = 57, step_err never asserts. Holding 12:34:57 for 20 more cycles gives no further pulses.
- Wrap and skip: drive 59:59:99 then 00:00:00 → no step_err. Then drive 00:00:05 → step_err = 1 with time_valid, step_err_cnt = 1.
- Malformed frames:
  - 1 cs units digit = 0001000 ("A") → fmt_err pulse, fmt_err_cnt = 1, outputs hold previous value.
  - digit3 = 6 (0000010) → fmt_err, fmt_err_cnt = 2.
- Glitch filter: with STABLE_CYCLES = 2, change digit0 for exactly 1 cycle then restore → no time_valid, no fmt_err, outputs unchanged.
- Saturation and reset: CNT_W = 2, inject 5 malformed frames → fmt_err_cnt = 3. Assert rst mid-filtering → counts 0 and no pulse from the interrupted frame.

Source files
------------

// File: rtl/seg_time_decoder.sv
// Stopwatch display-bus monitor: filters, validates and decodes six 7-segment digits (MM:SS:CC).
// Define SEG_DECODE_STEP_CHECK_EN to add the +1 cs step check and its error counter.

module seg_digit_dec #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [6:0] pat,
    output logic [3:0] val,
    output logic       ok
);
    logic [6:0] p;

    // Normalise to active-low g..a so one table serves both polarities.
    always_comb begin
        p   = (ACTIVE_LOW != 0) ? pat : ~pat;
        ok  = 1'b1;
        val = 4'd0;
        case (p)
            7'b1000000: val = 4'd0;
            7'b1111001: val = 4'd1;
            7'b0100100: val = 4'd2;
            7'b0110000: val = 4'd3;
            7'b0011001: val = 4'd4;
            7'b0010010: val = 4'd5;
            7'b0000010: val = 4'd6;
            7'b1111000: val = 4'd7;
            7'b0000000: val = 4'd8;
            7'b0010000: val = 4'd9;
            default:    ok  = 1'b0;
        endcase
    end
endmodule

module seg_time_decoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       digit5,
    input  logic [6:0]       digit4,
    input  logic [6:0]       digit3,
    input  logic [6:0]       digit2,
    input  logic [6:0]       digit1,
    input  logic [6:0]       digit0,
    output logic [5:0]       minutes,
    output logic [5:0]       seconds,
    output logic [6:0]       centis,
    output logic             time_valid,
    output logic             fmt_err,
    output logic             step_err,
    output logic [CNT_W-1:0] fmt_err_cnt,
    output logic [CNT_W-1:0] step_err_cnt
);
    localparam int NDIG = 6;
    localparam int SW   = 4;

    logic [NDIG-1:0][6:0] bus, in_q, last_frame;
    logic [NDIG-1:0][3:0] dval;
    logic [NDIG-1:0]      dok;
    logic [SW-1:0]        stab_cnt;
    logic                 last_vld;
    logic                 accept, frame_ok;
    logic [5:0]           new_min, new_sec;
    logic [6:0]           new_cs;

    assign bus = {digit5, digit4, digit3, digit2, digit1, digit0};

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_dig
            seg_digit_dec #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
                .pat (in_q[i]),
                .val (dval[i]),
                .ok  (dok[i])
            );
        end
    endgenerate

    // last_vld lets an all-zero bus be evaluated straight after reset.
    assign accept   = (stab_cnt == SW'(STABLE_CYCLES)) && (!last_vld || (in_q != last_frame));
    assign frame_ok = (&dok) && (dval[5] <= 4'd5) && (dval[3] <= 4'd5);
    assign new_min  = 6'(dval[5]) * 6'd10 + 6'(dval[4]);
    assign new_sec  = 6'(dval[3]) * 6'd10 + 6'(dval[2]);
    assign new_cs   = 7'(dval[1]) * 7'd10 + 7'(dval[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q        <= '0;
            stab_cnt    <= '0;
            last_frame  <= '0;
            last_vld    <= 1'b0;
            minutes     <= '0;
            seconds     <= '0;
            centis      <= '0;
            time_valid  <= 1'b0;
            fmt_err     <= 1'b0;
            fmt_err_cnt <= '0;
        end else begin
            in_q <= bus;
            if (bus != in_q)
                stab_cnt <= SW'(1);
            else if (stab_cnt != SW'(STABLE_CYCLES))
                stab_cnt <= stab_cnt + SW'(1);

            time_valid <= 1'b0;
            fmt_err    <= 1'b0;
            if (accept) begin
                last_frame <= in_q;
                last_vld   <= 1'b1;
                if (frame_ok) begin
                    minutes    <= new_min;
                    seconds    <= new_sec;
                    centis     <= new_cs;
                    time_valid <= 1'b1;
                end else begin
                    fmt_err <= 1'b1;
                    if (~&fmt_err_cnt)
                        fmt_err_cnt <= fmt_err_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef SEG_DECODE_STEP_CHECK_EN
    logic [5:0] p_min, p_sec, n_min, n_sec;
    logic [6:0] p_cs, n_cs;
    logic       have_prev, step_mis;

    // Previous good time plus one centisecond, wrapping 59:59:99 -> 00:00:00.
    always_comb begin
        n_min = p_min;
        n_sec = p_sec;
        n_cs  = p_cs + 7'd1;
        if (p_cs == 7'd99) begin
            n_cs  = 7'd0;
            n_sec = p_sec + 6'd1;
            if (p_sec == 6'd59) begin
                n_sec = 6'd0;
                n_min = (p_min == 6'd59) ? 6'd0 : p_min + 6'd1;
            end
        end
    end

    assign step_mis = have_prev && ({n_min, n_sec, n_cs} != {new_min, new_sec, new_cs});

    always_ff @(posedge clk) begin
        if (rst) begin
            p_min        <= '0;
            p_sec        <= '0;
            p_cs         <= '0;
            have_prev    <= 1'b0;
            step_err     <= 1'b0;
            step_err_cnt <= '0;
        end else begin
            step_err <= 1'b0;
            if (accept && frame_ok) begin
                p_min     <= new_min;
                p_sec     <= new_sec;
                p_cs      <= new_cs;
                have_prev <= 1'b1;
                if (step_mis) begin
                    step_err <= 1'b1;
                    if (~&step_err_cnt)
                        step_err_cnt <= step_err_cnt + CNT_W'(1);
                end
            end
        end
    end
`else
    assign step_err     = 1'b0;
    assign step_err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_time_decoder.sv
// Randomised and directed bench for seg_time_decoder against a frame-history reference model.
module tb_seg_time_decoder;
    localparam int S  = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [41:0] drv = '0;
    logic [6:0] digit5, digit4, digit3, digit2, digit1, digit0;
    logic [5:0] minutes, seconds;
    logic [6:0] centis;
    logic time_valid, fmt_err, step_err;
    logic [CW-1:0] fmt_err_cnt, step_err_cnt;

    assign {digit5, digit4, digit3, digit2, digit1, digit0} = drv;

    seg_time_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .digit5(digit5), .digit4(digit4), .digit3(digit3),
        .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .minutes(minutes), .seconds(seconds), .centis(centis),
        .time_valid(time_valid), .fmt_err(fmt_err), .step_err(step_err),
        .fmt_err_cnt(fmt_err_cnt), .step_err_cnt(step_err_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: bus samples since reset and expected outputs.
    logic [41:0] hist[$];
    logic [41:0] last_f;
    bit   last_v, have_p;
    int   prev_t;
    logic e_tv, e_fe, e_se;
    int   e_min, e_sec, e_cs, e_fc, e_sc;

    function automatic logic [41:0] enc(input int m, input int s, input int c);
        return {seg_tab[m/10], seg_tab[m%10], seg_tab[s/10], seg_tab[s%10], seg_tab[c/10], seg_tab[c%10]};
    endfunction

    function automatic logic [41:0] enc_t(input int t);
        return enc(t / 6000, (t / 100) % 60, t % 100);
    endfunction

    function automatic int dig(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [25:0] obs_v();
        return {time_valid, fmt_err, step_err, minutes, seconds, centis, fmt_err_cnt, step_err_cnt};
    endfunction

    function automatic logic [25:0] exp_v();
        return {e_tv, e_fe, e_se, 6'(e_min), 6'(e_sec), 7'(e_cs), 2'(e_fc), 2'(e_sc)};
    endfunction

    task automatic model_edge();
        int d[6];
        bit bad, stable;
        int t;
        logic [41:0] v;
        e_tv = 0; e_fe = 0; e_se = 0;
        if (rst) begin
            hist.delete();
            e_min = 0; e_sec = 0; e_cs = 0; e_fc = 0; e_sc = 0;
            last_v = 0; have_p = 0; prev_t = 0; last_f = '0;
        end else begin
            stable = (hist.size() >= S);
            v = '0;
            if (stable) begin
                v = hist[hist.size()-1];
                for (int i = 1; i <= S; i++) if (hist[hist.size()-i] != v) stable = 0;
            end
            if (stable && (!last_v || v != last_f)) begin
                last_f = v; last_v = 1; bad = 0;
                for (int i = 0; i < 6; i++) begin
                    d[i] = dig(v[i*7 +: 7]);
                    if (d[i] < 0) bad = 1;
                end
                if (d[5] > 5 || d[3] > 5) bad = 1;
                if (bad) begin
                    e_fe = 1;
                    if (e_fc < (1 << CW) - 1) e_fc++;
                end else begin
                    e_min = 10*d[5] + d[4]; e_sec = 10*d[3] + d[2]; e_cs = 10*d[1] + d[0];
                    e_tv = 1;
                    t = (e_min*60 + e_sec)*100 + e_cs;
`ifdef SEG_DECODE_STEP_CHECK_EN
                    if (have_p && t != (prev_t + 1) % 360000) begin
                        e_se = 1;
                        if (e_sc < (1 << CW) - 1) e_sc++;
                    end
`endif
                    prev_t = t; have_p = 1;
                end
            end
            hist.push_back(drv);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int tvs = 0;
        rst = 1; drv = enc(0, 0, 0);
        cyc(); cyc();
        vectors++;
        if (obs_v() !== 26'd0) begin
            miscompares++; $display("FAIL reset_state: got %h want 0", obs_v());
        end
        rst = 0;
        for (int i = 0; i < S + 1; i++) begin
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL reset_release cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            tvs += int'(time_valid);
        end
        vectors++;
        if (tvs != 1 || time_valid !== 1'b1 || {minutes, seconds, centis} !== 19'd0) begin
            miscompares++; $display("FAIL reset_first_frame: tv_count %0d tv %b time %h want 1 1 0", tvs, time_valid, {minutes, seconds, centis});
        end
    endtask

    task automatic test_step();
        int tvs = 0, ses = 0;
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 27; i++) begin
            drv = (i < 5) ? enc(12, 34, 56) : enc(12, 34, 57);
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL step cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            tvs += int'(time_valid); ses += int'(step_err);
        end
        vectors++;
        if (tvs != 2 || ses != 0 || {minutes, seconds, centis} !== {6'd12, 6'd34, 7'd57}) begin
            miscompares++; $display("FAIL step_summary: tv %0d se %0d time %0d:%0d:%0d want 2 0 12:34:57", tvs, ses, minutes, seconds, centis);
        end
    endtask

    task automatic test_wrap();
        int tvs = 0, ses = 0, want_se;
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < 12; i++) begin
            drv = (i < 4) ? enc(59, 59, 99) : (i < 8) ? enc(0, 0, 0) : enc(0, 0, 5);
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL wrap cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            tvs += int'(time_valid); ses += int'(step_err);
        end
`ifdef SEG_DECODE_STEP_CHECK_EN
        want_se = 1;
`else
        want_se = 0;
`endif
        vectors++;
        if (tvs != 3 || ses != want_se || int'(step_err_cnt) != want_se || centis !== 7'd5) begin
            miscompares++; $display("FAIL wrap_skip: tv %0d se %0d cnt %0d cs %0d want 3 %0d %0d 5", tvs, ses, step_err_cnt, centis, want_se, want_se);
        end
    endtask

    task automatic test_malformed();
        int fes = 0, tvs = 0;
        logic [41:0] f;
        f = enc(0, 0, 5); f[6:0] = 7'b0001000;
        drv = f;
        for (int i = 0; i < 4; i++) begin
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL malformed_a cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            fes += int'(fmt_err); tvs += int'(time_valid);
        end
        vectors++;
        if (fes != 1 || tvs != 0 || fmt_err_cnt !== 2'd1 || centis !== 7'd5) begin
            miscompares++; $display("FAIL malformed_hex: fe %0d tv %0d cnt %0d cs %0d want 1 0 1 5", fes, tvs, fmt_err_cnt, centis);
        end
        fes = 0;
        drv = enc(0, 60, 5);
        for (int i = 0; i < 4; i++) begin
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL malformed_sec cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            fes += int'(fmt_err);
        end
        vectors++;
        if (fes != 1 || fmt_err_cnt !== 2'd2 || seconds !== 6'd0) begin
            miscompares++; $display("FAIL malformed_tens: fe %0d cnt %0d sec %0d want 1 2 0", fes, fmt_err_cnt, seconds);
        end
    endtask

    task automatic test_glitch();
        int tvs = 0, fes = 0;
        logic [41:0] g;
        drv = enc(0, 0, 6);
        for (int i = 0; i < 4; i++) cyc();
        vectors++;
        if (centis !== 7'd6) begin
            miscompares++; $display("FAIL glitch_setup: got cs %0d want 6", centis);
        end
        g = drv; g[6:0] = seg_tab[7];
        for (int i = 0; i < 6; i++) begin
            drv = (i == 0) ? g : enc(0, 0, 6);
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL glitch cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
            tvs += int'(time_valid); fes += int'(fmt_err);
        end
        vectors++;
        if (tvs != 0 || fes != 0 || centis !== 7'd6) begin
            miscompares++; $display("FAIL glitch_filter: tv %0d fe %0d cs %0d want 0 0 6", tvs, fes, centis);
        end
    endtask

    task automatic test_saturation();
        int fes = 0;
        logic [41:0] f;
        for (int k = 1; k <= 5; k++) begin
            f = enc(0, 0, 10*k + 6); f[6:0] = 7'h7F;
            drv = f;
            for (int i = 0; i < 3; i++) begin
                cyc(); vectors++;
                if (obs_v() !== exp_v()) begin
                    miscompares++; $display("FAIL sat k%0d cyc%0d: got %h want %h", k, i, obs_v(), exp_v());
                end
                fes += int'(fmt_err);
            end
        end
        vectors++;
        if (fes != 5 || fmt_err_cnt !== 2'd3) begin
            miscompares++; $display("FAIL sat_count: fe %0d cnt %0d want 5 3", fes, fmt_err_cnt);
        end
        drv = enc(1, 2, 3); cyc();
        rst = 1; drv = enc(4, 5, 6); cyc();
        vectors++;
        if ({fmt_err_cnt, step_err_cnt, time_valid, fmt_err} !== 6'd0) begin
            miscompares++; $display("FAIL reset_midframe: got %b want 0", {fmt_err_cnt, step_err_cnt, time_valid, fmt_err});
        end
        rst = 0;
        for (int i = 0; i < S + 1; i++) begin
            cyc(); vectors++;
            if (obs_v() !== exp_v()) begin
                miscompares++; $display("FAIL reset_refilter cyc%0d: got %h want %h", i, obs_v(), exp_v());
            end
        end
        vectors++;
        if (time_valid !== 1'b1 || {minutes, seconds, centis} !== {6'd4, 6'd5, 7'd6}) begin
            miscompares++; $display("FAIL reset_newframe: tv %b time %0d:%0d:%0d want 1 4:5:6", time_valid, minutes, seconds, centis);
        end
    endtask

    task automatic test_random();
        int t, kind, hold;
        logic [41:0] f, g;
        rst = 1; cyc(); rst = 0;
        t = $urandom_range(0, 359999);
        for (int seg = 0; seg < 150; seg++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)      t = (t + 1) % 360000;
            else if (kind == 6) t = $urandom_range(0, 359999);
            else if (kind == 7) t = (t + 2) % 360000;
            f = enc_t(t);
            if (kind == 8) f[$urandom_range(0, 5)*7 +: 7] = 7'($urandom);
            g = f; g[$urandom_range(0, 5)*7 +: 7] = 7'($urandom);
            hold = $urandom_range(1, 4);
            for (int i = 0; i < hold + 1; i++) begin
                rst = ($urandom_range(0, 99) == 0);
                drv = (kind == 9 && i == 0) ? g : f;
                cyc(); vectors++;
                if (obs_v() !== exp_v()) begin
                    miscompares++; $display("FAIL random seg%0d cyc%0d: got %h want %h", seg, i, obs_v(), exp_v());
                end
            end
            rst = 0;
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_wrap();
        test_malformed();
        test_glitch();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
